// File: rtl/wb_arb_pkg.sv
// Shared definitions for the dual-master Wishbone arbiter.
//   arb_state_t : FSM state encoding (IDLE / GNT_D / GNT_I)
//   to_w()      : width of the timeout counter for a given TIMEOUT
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_D = 2'd1,
      GNT_I = 2'd2
   } arb_state_t;

   // TO_W = $clog2(TIMEOUT+1); yields 0 for TIMEOUT = 0, callers clamp to 1
   function automatic int to_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/wb_dual_master_arbiter_if.sv
// Wishbone bundle around the arbiter: data master, instruction master and
// the shared slave.
//   slave  modport : the arbiter's view (accepts master requests, drives slave)
//   master modport : the environment's view (drives master requests and the
//                    slave response)
interface wb_dual_master_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // data master
   logic            d_cyc_i, d_stb_i, d_we_i;
   logic [AW-1:0]   d_adr_i;
   logic [DW-1:0]   d_dat_i;
   logic [DW/8-1:0] d_sel_i;
   logic [DW-1:0]   d_dat_o;
   logic            d_ack_o, d_err_o;
   // instruction master (read-only)
   logic            i_cyc_i, i_stb_i;
   logic [AW-1:0]   i_adr_i;
   logic [DW-1:0]   i_dat_o;
   logic            i_ack_o, i_err_o;
   // shared slave
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [DW/8-1:0] s_sel_o;
   logic [DW-1:0]   s_dat_i;
   logic            s_ack_i, s_err_i;

   modport slave (
      input  d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_dat_i, d_sel_i,
      output d_dat_o, d_ack_o, d_err_o,
      input  i_cyc_i, i_stb_i, i_adr_i,
      output i_dat_o, i_ack_o, i_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  s_dat_i, s_ack_i, s_err_i
   );

   modport master (
      output d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_dat_i, d_sel_i,
      input  d_dat_o, d_ack_o, d_err_o,
      output i_cyc_i, i_stb_i, i_adr_i,
      input  i_dat_o, i_ack_o, i_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output s_dat_i, s_ack_i, s_err_i
   );

endinterface

// File: rtl/wb_timeout_counter.sv
// Bus-timeout counter for a granted transaction.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (held while the arbiter is idle)
//   enable     : count this cycle (a transaction is outstanding)
//   expired    : high in the cycle where the count reaches TIMEOUT-1
// TIMEOUT = 0 disables expiry; the counter then just wraps harmlessly.
module wb_timeout_counter
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TO_W = to_w(TIMEOUT);
   localparam int CW   = (TO_W < 1) ? 1 : TO_W;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
   end

   assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter. Data port wins ties unless
// it held the previous grant; a hung slave is turned into an err response
// after TIMEOUT cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : data master, instruction master and slave signals
//   grant_o    : registered grant, bit0 = data, bit1 = instruction
//   timeout_o  : one-cycle pulse when a timeout err is issued
module wb_dual_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   wb_dual_master_arbiter_if.slave   bus,
   output logic [1:0]                grant_o,
   output logic                      timeout_o
);

   arb_state_t state, state_nxt;
   logic       last_d;
   logic       req_d, req_i;
   logic       gnt_d, gnt_i;
   logic       cyc_x;       // cyc of whichever master holds the grant
   logic       expired;
   logic       to_pulse;

   assign req_d = bus.d_cyc_i & bus.d_stb_i;
   assign req_i = bus.i_cyc_i & bus.i_stb_i;
   assign gnt_d = (state == GNT_D);
   assign gnt_i = (state == GNT_I);
   assign cyc_x = (gnt_d & bus.d_cyc_i) | (gnt_i & bus.i_cyc_i);

   // counting only while the owner keeps cyc up; an abort is not a timeout
   wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_to (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == IDLE),
      .enable  (cyc_x),
      .expired (expired)
   );

   // a real slave response in the expiry cycle takes precedence
   assign to_pulse  = expired & ~bus.s_ack_i & ~bus.s_err_i;
   assign timeout_o = to_pulse;
   assign grant_o   = {gnt_i, gnt_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == GNT_D) last_d <= 1'b1;
         if (state == IDLE && state_nxt == GNT_I) last_d <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_d && (!req_i || !last_d)) state_nxt = GNT_D;
            else if (req_i)                   state_nxt = GNT_I;
         end
         GNT_D, GNT_I: begin
            if (!cyc_x || bus.s_ack_i || bus.s_err_i || expired) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // slave request mux and response demux; IDLE drives everything to zero
   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      bus.d_ack_o = 1'b0;
      bus.d_err_o = 1'b0;
      bus.d_dat_o = '0;
      bus.i_ack_o = 1'b0;
      bus.i_err_o = 1'b0;
      bus.i_dat_o = '0;
      if (gnt_d) begin
         bus.s_cyc_o = bus.d_cyc_i;
         bus.s_stb_o = bus.d_cyc_i & bus.d_stb_i;
         bus.s_we_o  = bus.d_we_i;
         bus.s_adr_o = bus.d_adr_i;
         bus.s_dat_o = bus.d_dat_i;
         bus.s_sel_o = bus.d_sel_i;
         bus.d_ack_o = bus.d_cyc_i & bus.s_ack_i;
         bus.d_err_o = bus.d_cyc_i & (bus.s_err_i | to_pulse);
         bus.d_dat_o = bus.s_dat_i;
      end else if (gnt_i) begin
         bus.s_cyc_o = bus.i_cyc_i;
         bus.s_stb_o = bus.i_cyc_i & bus.i_stb_i;
         bus.s_adr_o = bus.i_adr_i;
         bus.s_sel_o = '1;
         bus.i_ack_o = bus.i_cyc_i & bus.s_ack_i;
         bus.i_err_o = bus.i_cyc_i & (bus.s_err_i | to_pulse);
         bus.i_dat_o = bus.s_dat_i;
      end
   end

endmodule
